// File: rtl/mem_vector_sequencer.sv
// Strided vector load/store sequencer for the six-bank byte-wide unified memory.
// Optional abort input is enabled with `define MEMSEQ_ABORT_EN.
module mem_vector_sequencer #(
  parameter int WIDTH = 16,
  parameter int LENW  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef MEMSEQ_ABORT_EN
  input  logic               abort,
`endif
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_store,
  input  logic [WIDTH-1:0]   cmd_base,
  input  logic [WIDTH-1:0]   cmd_stride,
  input  logic [LENW-1:0]    cmd_len,
  input  logic [5:0]         cmd_mask,
  input  logic               wdat_valid,
  output logic               wdat_ready,
  input  logic [47:0]        wdat,
  output logic               rdat_valid,
  input  logic               rdat_ready,
  output logic [47:0]        rdat,
  output logic               done,
  output logic [5:0]         mem_we,
  output logic [WIDTH*6-1:0] mem_a,
  output logic [WIDTH*6-1:0] mem_wd,
  input  logic [47:0]        mem_rd
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] LAST = 2'd2;

  logic [1:0]       state;
  logic             store_q;
  logic [WIDTH-1:0] stride_q;
  logic [WIDTH-1:0] addr_q;
  logic [5:0]       mask_q;
  logic [LENW-1:0]  cnt_q;
  logic [47:0]      byte_mask;
  logic             abort_hit;
  logic             cmd_fire;
  logic             store_run;
  logic             wr_fire;
  logic             ld_fire;

`ifdef MEMSEQ_ABORT_EN
  assign abort_hit = abort && (state != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign cmd_ready  = (state == IDLE);
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign store_run  = (state == RUN) && store_q && !abort_hit;
  assign wdat_ready = store_run;
  assign wr_fire    = store_run && wdat_valid;
  assign mem_we     = wr_fire ? mask_q : 6'b0;
  // A load beat may be captured whenever the output register is empty or draining.
  assign ld_fire    = (state == RUN) && !store_q && !abort_hit && (!rdat_valid || rdat_ready);

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    mem_a     = '0;
    mem_wd    = '0;
    byte_mask = '0;
    for (int i = 0; i < 6; i++) begin
      mem_a[i*WIDTH +: WIDTH]  = addr_q;
      mem_wd[i*WIDTH +: WIDTH] = {{(WIDTH-8){1'b0}}, wdat[i*8 +: 8]};
      byte_mask[i*8 +: 8]      = {8{mask_q[i]}};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      store_q    <= 1'b0;
      stride_q   <= '0;
      addr_q     <= '0;
      mask_q     <= '0;
      cnt_q      <= '0;
      rdat       <= '0;
      rdat_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort_hit) begin
        state      <= IDLE;
        rdat_valid <= 1'b0;
        done       <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (cmd_fire) begin
              if (cmd_len != '0) begin
                state    <= RUN;
                store_q  <= cmd_store;
                stride_q <= cmd_stride;
                mask_q   <= cmd_mask;
                addr_q   <= cmd_base;
                cnt_q    <= cmd_len;
              end else begin
                done <= 1'b1;
              end
            end
          end
          RUN: begin
            if (wr_fire || ld_fire) begin
              addr_q <= addr_q + stride_q;
              cnt_q  <= cnt_q - 1'b1;
              if (cnt_q == LENW'(1)) begin
                state <= store_q ? IDLE : LAST;
                done  <= store_q;
              end
            end
            if (ld_fire) begin
              rdat       <= mem_rd & byte_mask;
              rdat_valid <= 1'b1;
            end
          end
          LAST: begin
            if (rdat_valid && rdat_ready) begin
              state      <= IDLE;
              rdat_valid <= 1'b0;
              done       <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_vector_sequencer.sv
// Directed self-checking bench for mem_vector_sequencer with a six-bank byte memory model.
module tb_mem_vector_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        abort;
  logic        cmd_valid, cmd_ready, cmd_store;
  logic [15:0] cmd_base, cmd_stride;
  logic [3:0]  cmd_len;
  logic [5:0]  cmd_mask;
  logic        wdat_valid, wdat_ready;
  logic [47:0] wdat;
  logic        rdat_valid, rdat_ready;
  logic [47:0] rdat;
  logic        done;
  logic [5:0]  mem_we;
  logic [95:0] mem_a, mem_wd;
  logic [47:0] mem_rd;

  int n_cmp = 0;
  int n_err = 0;

  logic       mem_clr;
  logic [7:0] wm [6][65536];
  logic       wv [6][65536];

  always #5 clk = ~clk;

  mem_vector_sequencer dut (
    .clk(clk), .rst_n(rst_n),
`ifdef MEMSEQ_ABORT_EN
    .abort(abort),
`endif
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_store(cmd_store),
    .cmd_base(cmd_base), .cmd_stride(cmd_stride), .cmd_len(cmd_len), .cmd_mask(cmd_mask),
    .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat(wdat),
    .rdat_valid(rdat_valid), .rdat_ready(rdat_ready), .rdat(rdat),
    .done(done), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // Background contents of the memory before any store.
  function automatic logic [7:0] pat(int i, int a);
    return 8'((a * 5) ^ (i * 37) ^ 8'h5A);
  endfunction

  function automatic logic [7:0] rd(int i, logic [15:0] a);
    return wv[i][a] ? wm[i][a] : pat(i, int'(a));
  endfunction

  function automatic logic [47:0] exp_rd(logic [15:0] a, logic [5:0] m);
    logic [47:0] r = '0;
    for (int i = 0; i < 6; i++) if (m[i]) r[i*8 +: 8] = pat(i, int'(a));
    return r;
  endfunction

  always_comb begin
    mem_rd = '0;
    for (int i = 0; i < 6; i++) mem_rd[i*8 +: 8] = rd(i, mem_a[i*16 +: 16]);
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 6; i++) for (int a = 0; a < 65536; a++) wv[i][a] <= 1'b0;
    end else begin
      for (int i = 0; i < 6; i++) if (mem_we[i]) begin
        wm[i][mem_a[i*16 +: 16]] <= mem_wd[i*16 +: 8];
        wv[i][mem_a[i*16 +: 16]] <= 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic st, input logic [15:0] b, input logic [15:0] s,
                       input logic [3:0] l, input logic [5:0] m);
    cmd_valid = 1'b1; cmd_store = st; cmd_base = b; cmd_stride = s; cmd_len = l; cmd_mask = m;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; mem_clr = 1'b1; abort = 1'b0;
    cmd_valid = 1'b0; cmd_store = 1'b0; cmd_base = '0; cmd_stride = '0; cmd_len = '0; cmd_mask = '0;
    wdat_valid = 1'b0; wdat = '0; rdat_ready = 1'b0;
    step(); step();
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_wdat_ready", wdat_ready, 1'b0);
    check("rst_rdat_valid", rdat_valid, 1'b0);
    check("rst_rdat", rdat, 48'h0);
    check("rst_done", done, 1'b0);
    check("rst_mem_we", mem_we, 6'h00);
    check("rst_mem_a", mem_a, 96'h0);
    rst_n = 1'b1; mem_clr = 1'b0;
    step();

    // Load base 0 stride 1 len 3, full mask, sink always ready
    rdat_ready = 1'b1;
    offer(1'b0, 16'h0000, 16'h0001, 4'd3, 6'h3F);
    check("ld1_busy", cmd_ready, 1'b0);
    step(); check("ld1_b0", rdat, exp_rd(16'h0000, 6'h3F)); check("ld1_v0", rdat_valid, 1'b1);
    step(); check("ld1_b1", rdat, exp_rd(16'h0001, 6'h3F));
    step(); check("ld1_b2", rdat, exp_rd(16'h0002, 6'h3F)); check("ld1_nodone", done, 1'b0);
    step(); check("ld1_done", done, 1'b1); check("ld1_vlow", rdat_valid, 1'b0);
    check("ld1_idle", cmd_ready, 1'b1);
    step(); check("ld1_done_pulse", done, 1'b0);

    // Store base 2 stride 1 len 2, lane 3 only, one stalled cycle first
    offer(1'b1, 16'h0002, 16'h0001, 4'd2, 6'h08);
    check("st_wready", wdat_ready, 1'b1);
    check("st_stall_we", mem_we, 6'h00);
    step();
    wdat_valid = 1'b1; wdat = 48'h1122AA334455; #1;
    check("st_we0", mem_we, 6'h08);
    check("st_a0", mem_a, {6{16'h0002}});
    check("st_wd0", mem_wd, {16'h0011, 16'h0022, 16'h00AA, 16'h0033, 16'h0044, 16'h0055});
    step();
    wdat = 48'h1122BB334455; #1;
    check("st_we1", mem_we, 6'h08);
    check("st_a1", mem_a, {6{16'h0003}});
    step();
    wdat_valid = 1'b0; #1;
    check("st_done", done, 1'b1);
    check("st_wready_off", wdat_ready, 1'b0);
    check("st_we_off", mem_we, 6'h00);
    check("st_b3_2", rd(3, 16'h0002), 8'hAA);
    check("st_b3_3", rd(3, 16'h0003), 8'hBB);
    check("st_b2_2", rd(2, 16'h0002), pat(2, 2));
    check("st_b4_3", rd(4, 16'h0003), pat(4, 3));

    // Load len 4 with backpressure after first beat, partial mask
    offer(1'b0, 16'h000A, 16'h0003, 4'd4, 6'h15);
    step(); check("bp_b0", rdat, exp_rd(16'h000A, 6'h15));
    rdat_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_hold_rdat", rdat, exp_rd(16'h000A, 6'h15));
      check("bp_hold_valid", rdat_valid, 1'b1);
      check("bp_hold_a", mem_a, {6{16'h000D}});
    end
    rdat_ready = 1'b1;
    step(); check("bp_b1", rdat, exp_rd(16'h000D, 6'h15));
    step(); check("bp_b2", rdat, exp_rd(16'h0010, 6'h15));
    step(); check("bp_b3", rdat, exp_rd(16'h0013, 6'h15));
    step(); check("bp_done", done, 1'b1);

    // Address wrap
    offer(1'b0, 16'hFFFF, 16'h0002, 4'd2, 6'h3F);
    check("wr_a0", mem_a, {6{16'hFFFF}});
    step(); check("wr_a1", mem_a, {6{16'h0001}}); check("wr_b0", rdat, exp_rd(16'hFFFF, 6'h3F));
    step(); check("wr_b1", rdat, exp_rd(16'h0001, 6'h3F));
    step(); check("wr_done", done, 1'b1);

    // Zero-length store is a no-op with a done pulse
    wdat_valid = 1'b1;
    offer(1'b1, 16'h0040, 16'h0001, 4'd0, 6'h3F);
    check("z_done", done, 1'b1);
    check("z_ready", cmd_ready, 1'b1);
    check("z_we", mem_we, 6'h00);
    wdat_valid = 1'b0;
    step();

    // Zero mask load still sequences, returns zeros
    offer(1'b0, 16'h0005, 16'h0001, 4'd1, 6'h00);
    step(); check("m0_valid", rdat_valid, 1'b1); check("m0_rdat", rdat, 48'h0);
    step(); check("m0_done", done, 1'b1);

    // Reset in the middle of a store
    offer(1'b1, 16'h0064, 16'h0001, 4'd3, 6'h3F);
    wdat_valid = 1'b1; wdat = 48'hFFFFFFFFFFFF; #1;
    check("rs_we_before", mem_we, 6'h3F);
    rst_n = 1'b0; #1;
    check("rs_we", mem_we, 6'h00);
    check("rs_cmd_ready", cmd_ready, 1'b1);
    check("rs_rdat_valid", rdat_valid, 1'b0);
    wdat_valid = 1'b0;
    step();
    check("rs_mem", rd(0, 16'h0064), pat(0, 100));
    rst_n = 1'b1;
    step();

`ifdef MEMSEQ_ABORT_EN
    offer(1'b0, 16'h0020, 16'h0001, 4'd5, 6'h3F);
    step(); step();
    check("ab_pre_valid", rdat_valid, 1'b1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("ab_valid", rdat_valid, 1'b0);
    check("ab_done", done, 1'b1);
    check("ab_ready", cmd_ready, 1'b1);
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
